uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one uart_tx byte interface between P_REQ_NUM requesters.
- Each requester sends packets of bytes on a valid/ready/last stream.
- The arbiter locks a grant for a whole packet, or until P_MAX_BURST bytes have been sent, then rotates to the next requester.
- Sits between the user-side byte producers and the uart_tx i_user_tx_data / i_uart_tx_valid / o_user_tx_ready handshake.

Parameters:
- P_UART_DATAWIDTH, 8, byte width; must match uart_tx.
- P_REQ_NUM, 4, number of requesters (2..8).
- P_MAX_BURST, 16, maximum bytes per grant before forced release (1..255).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous reset, active-low (i_rst=0 resets).
- i_req_data  input  P_REQ_NUM*P_UART_DATAWIDTH  requester bytes; requester k occupies bits [k*W +: W].
- i_req_valid  input  P_REQ_NUM  per-requester byte valid.
- i_req_last  input  P_REQ_NUM  per-requester last byte of packet; qualified by valid.
- o_req_ready  output  P_REQ_NUM  per-requester ready.
- o_tx_data  output  P_UART_DATAWIDTH  to uart_tx i_user_tx_data.
- o_tx_valid  output  1  to uart_tx i_uart_tx_valid.
- i_tx_ready  input  1  from uart_tx o_user_tx_ready.
- o_grant  output  P_REQ_NUM  one-hot current grant; 0 when idle.
- o_busy  output  1  high while in GRANT.

Behaviour:
- Reset (i_rst low, asynchronous):
  - state=IDLE, o_grant=0, last-grant pointer=P_REQ_NUM-1 (so requester 0 has first priority).
  - burst count=0; o_tx_valid=0, o_req_ready=0, o_tx_data=0, o_busy=0.
- Transfer definition: a transfer occurs on a rising clock edge when o_tx_valid && i_tx_ready.
- IDLE state:
  - o_grant=0, o_tx_valid=0, o_req_ready=0.
  - If any i_req_valid bit is high, select the first valid requester searching upward from pointer+1, wrapping modulo P_REQ_NUM.
  - Register that selection into o_grant and go to GRANT. Arbitration latency is 1 cycle.
- GRANT state, combinational pass-through from granted requester g:
  - o_tx_data = i_req_data[g]
  - o_tx_valid = i_req_valid[g]
  - o_req_ready[g] = i_tx_ready
  - all other o_req_ready bits = 0
- Burst counter:
  - Increments on each transfer.
  - Width is the minimum needed to hold P_MAX_BURST.
- Release: on a transfer where i_req_last[g]=1, or where the count reaches P_MAX_BURST:
  - next state IDLE, pointer=g, count=0, o_grant=0 on the next cycle.
  - Each release therefore adds one idle cycle before the next grant.
- Lock: while in GRANT, a drop of i_req_valid[g] does not release the grant; the arbiter waits (no timeout).
  - Valid from other requesters is ignored until release.
- Forced release mid-packet (burst limit hit):
  - The requester's remaining bytes resume when it next wins arbitration.
  - No bytes are lost or duplicated.
- Simultaneous requests: exactly one grant, by round-robin order.
  - A requester that was just released has lowest priority in the next arbitration.
- Single requester active: re-granted after the one IDLE cycle.
- i_tx_ready low: o_tx_valid and data are held from the requester side.
  - Requesters must hold data while valid and not ready (AXI-style rule); the arbiter does not buffer.
- Reset asserted mid-packet: immediate return to reset values. The partial packet is abandoned.

Test Plan:
- Reset, then requester 1 sends a 3-byte packet 0xA1,0xA2,0xA3 (last on 0xA3), tx_ready tied 1:
  - o_grant=4'b0010 one cycle after valid.
  - Three transfers in consecutive cycles with the correct data.
  - o_grant=0 on the cycle after 0xA3.
- All 4 requesters valid with 1-byte packets 0x10,0x20,0x30,0x40 simultaneously after reset:
  - Grant order 0,1,2,3.
  - Output byte order 0x10,0x20,0x30,0x40, with one idle cycle between grants.
- Requester 2 sends 20 bytes 0x00..0x13 (last on 0x13) with P_MAX_BURST=16 while requester 3 is also valid:
  - Bytes 0x00..0x0F go out, then release.
  - Requester 3's packet goes out.
  - Then 0x10..0x13 from requester 2.
- uart_tx-style ready (ready low for 10 cycles after each transfer), requester 0 sending 0x55,0xAA:
  - o_tx_valid stays high while ready is low.
  - Exactly 2 transfers occur; o_req_ready[0] mirrors i_tx_ready.
- Requester 1 granted, sends byte 0x01, then deasserts valid for 5 cycles while requester 0 is valid:
  - o_grant stays 4'b0010.
  - On resumption, 0x02 with last transfers, and only then is requester 0 granted.
- Assert i_rst low mid-packet:
  - Asynchronously o_grant=0, o_tx_valid=0, o_busy=0.
  - After release, requester 0 has top priority.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between N requesters, the arbiter and the uart_tx user handshake.
// The arbiter takes the slave modport; the requester/uart_tx side takes the master modport.
interface uart_tx_arbiter_if #(
   parameter int P_UART_DATAWIDTH = 8,
   parameter int P_REQ_NUM        = 4
);
   logic [P_REQ_NUM*P_UART_DATAWIDTH-1:0] i_req_data;
   logic [P_REQ_NUM-1:0]                  i_req_valid;
   logic [P_REQ_NUM-1:0]                  i_req_last;
   logic [P_REQ_NUM-1:0]                  o_req_ready;
   logic [P_UART_DATAWIDTH-1:0]           o_tx_data;
   logic                                  o_tx_valid;
   logic                                  i_tx_ready;
   logic [P_REQ_NUM-1:0]                  o_grant;
   logic                                  o_busy;

   modport slave (
      input  i_req_data, i_req_valid, i_req_last, i_tx_ready,
      output o_req_ready, o_tx_data, o_tx_valid, o_grant, o_busy
   );

   modport master (
      output i_req_data, i_req_valid, i_req_last, i_tx_ready,
      input  o_req_ready, o_tx_data, o_tx_valid, o_grant, o_busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte port between P_REQ_NUM packet requesters.
// A grant is held for a whole packet or P_MAX_BURST bytes, whichever comes first.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no grant; pick next valid requester after ptr_q (1 cycle)
//   ST_GRANT | granted requester passed straight through to uart_tx
module uart_tx_arbiter #(
   parameter int P_UART_DATAWIDTH = 8,
   parameter int P_REQ_NUM        = 4,
   parameter int P_MAX_BURST      = 16
) (
   input logic               i_clk,
   input logic               i_rst,
   uart_tx_arbiter_if.slave  bus
);
   localparam int W  = P_UART_DATAWIDTH;
   localparam int IW = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;
   localparam int CW = (P_MAX_BURST > 1) ? $clog2(P_MAX_BURST + 1) : 1;
   localparam logic [CW-1:0] BURST_TC = CW'(P_MAX_BURST - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [P_REQ_NUM-1:0] grant_q, grant_d;
   logic [IW-1:0]        gidx_q, gidx_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic [W-1:0]         req_bytes [P_REQ_NUM];
   logic                 sel_found;
   logic [IW-1:0]        sel_idx;
   logic [IW-1:0]        cand_idx;
   int                   cand;

   logic [W-1:0]         tx_data;
   logic                 tx_valid;
   logic [P_REQ_NUM-1:0] req_ready;
   logic                 xfer;

   always_comb begin
      for (int k = 0; k < P_REQ_NUM; k++) begin
         req_bytes[k] = bus.i_req_data[k*W +: W];
      end
   end

   // search upward from the last grant so the just-released requester is last in line
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 1; i <= P_REQ_NUM; i++) begin
         cand     = (int'(ptr_q) + i) % P_REQ_NUM;
         cand_idx = IW'(cand);
         if (!sel_found && bus.i_req_valid[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gidx_d    = gidx_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      tx_data   = '0;
      tx_valid  = 1'b0;
      req_ready = '0;
      xfer      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sel_found) begin
               state_d          = ST_GRANT;
               gidx_d           = sel_idx;
               grant_d          = '0;
               grant_d[sel_idx] = 1'b1;
            end
         end

         ST_GRANT: begin
            tx_data           = req_bytes[gidx_q];
            tx_valid          = bus.i_req_valid[gidx_q];
            req_ready[gidx_q] = bus.i_tx_ready;
            xfer              = tx_valid && bus.i_tx_ready;
            if (xfer) begin
               if (bus.i_req_last[gidx_q] || (cnt_q == BURST_TC)) begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  ptr_d   = gidx_q;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= IW'(P_REQ_NUM - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.o_tx_data   = tx_data;
   assign bus.o_tx_valid  = tx_valid;
   assign bus.o_req_ready = req_ready;
   assign bus.o_grant     = grant_q;
   assign bus.o_busy      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus hand-written
// sequences for burst release, slow tx_ready and asynchronous reset.
module tb_uart_tx_arbiter;
   localparam int W = 8;
   localparam int N = 4;
   localparam int B = 16;

   logic clk;
   logic rst_n;
   int   n_err;
   int   n_checks;

   uart_tx_arbiter_if #(.P_UART_DATAWIDTH(W), .P_REQ_NUM(N)) bus ();

   uart_tx_arbiter #(
      .P_UART_DATAWIDTH(W),
      .P_REQ_NUM(N),
      .P_MAX_BURST(B)
   ) dut (
      .i_clk(clk),
      .i_rst(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic [31:0] data;
      logic        rdy;
      logic [3:0]  e_grant;
      logic        e_valid;
      logic [7:0]  e_data;
      logic [3:0]  e_ready;
      logic        e_busy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                               input logic [31:0] d, input logic rd, input logic [3:0] eg,
                               input logic ev, input logic [7:0] ed, input logic [3:0] er,
                               input logic eb);
      vec_t t;
      t.rst = r; t.valid = v; t.last = l; t.data = d; t.rdy = rd;
      t.e_grant = eg; t.e_valid = ev; t.e_data = ed; t.e_ready = er; t.e_busy = eb;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                        input logic rd);
      bus.i_req_valid = v;
      bus.i_req_last  = l;
      bus.i_req_data  = d;
      bus.i_tx_ready  = rd;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(4'b0, 4'b0, 32'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // test 3 state
   int          r2, r3, cyc;
   logic [7:0]  got_data[$];
   logic [3:0]  got_grant[$];
   logic [7:0]  exp_data[$];
   logic [3:0]  exp_grant[$];
   logic [31:0] dw;
   logic [3:0]  vw, lw;
   // test 4 state
   int          idx, rdy_cnt, nx;
   logic        g_exp, rdy, v0, xfer_m;

   initial begin
      n_err    = 0;
      n_checks = 0;
      rst_n    = 1'b0;
      drive(4'b0, 4'b0, 32'h0, 1'b0);

      // requester 1, 3-byte packet
      tbl.push_back(mk(1, 4'b0010, 4'b0000, 32'h0000A100, 1, 4'b0000, 0, 8'h00, 4'b0000, 0));
      tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000A100, 1, 4'b0010, 1, 8'hA1, 4'b0010, 1));
      tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000A200, 1, 4'b0010, 1, 8'hA2, 4'b0010, 1));
      tbl.push_back(mk(0, 4'b0010, 4'b0010, 32'h0000A300, 1, 4'b0010, 1, 8'hA3, 4'b0010, 1));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0));
      // all four valid, 1-byte packets
      tbl.push_back(mk(1, 4'b1111, 4'b1111, 32'h40302010, 1, 4'b0000, 0, 8'h00, 4'b0000, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h40302010, 1, 4'b0001, 1, 8'h10, 4'b0001, 1));
      tbl.push_back(mk(0, 4'b1110, 4'b1111, 32'h40302010, 1, 4'b0000, 0, 8'h00, 4'b0000, 0));
      tbl.push_back(mk(0, 4'b1110, 4'b1111, 32'h40302010, 1, 4'b0010, 1, 8'h20, 4'b0010, 1));
      tbl.push_back(mk(0, 4'b1100, 4'b1111, 32'h40302010, 1, 4'b0000, 0, 8'h00, 4'b0000, 0));
      tbl.push_back(mk(0, 4'b1100, 4'b1111, 32'h40302010, 1, 4'b0100, 1, 8'h30, 4'b0100, 1));
      tbl.push_back(mk(0, 4'b1000, 4'b1111, 32'h40302010, 1, 4'b0000, 0, 8'h00, 4'b0000, 0));
      tbl.push_back(mk(0, 4'b1000, 4'b1111, 32'h40302010, 1, 4'b1000, 1, 8'h40, 4'b1000, 1));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h40302010, 1, 4'b0000, 0, 8'h00, 4'b0000, 0));
      // lock: requester 1 drops valid mid-packet while requester 0 waits
      tbl.push_back(mk(1, 4'b0010, 4'b0000, 32'h00000100, 1, 4'b0000, 0, 8'h00, 4'b0000, 0));
      tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h00000100, 1, 4'b0010, 1, 8'h01, 4'b0010, 1));
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(0, 4'b0001, 4'b0001, 32'h00000077, 1, 4'b0010, 0, 8'h00, 4'b0010, 1));
      tbl.push_back(mk(0, 4'b0011, 4'b0011, 32'h00000277, 1, 4'b0010, 1, 8'h02, 4'b0010, 1));
      tbl.push_back(mk(0, 4'b0001, 4'b0001, 32'h00000077, 1, 4'b0000, 0, 8'h00, 4'b0000, 0));
      tbl.push_back(mk(0, 4'b0001, 4'b0001, 32'h00000077, 1, 4'b0001, 1, 8'h77, 4'b0001, 1));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         @(negedge clk);
         drive(tbl[i].valid, tbl[i].last, tbl[i].data, tbl[i].rdy);
         #1;
         chk($sformatf("v%0d.grant", i), 32'(bus.o_grant), 32'(tbl[i].e_grant));
         chk($sformatf("v%0d.tx_valid", i), 32'(bus.o_tx_valid), 32'(tbl[i].e_valid));
         chk($sformatf("v%0d.tx_data", i), 32'(bus.o_tx_data), 32'(tbl[i].e_data));
         chk($sformatf("v%0d.req_ready", i), 32'(bus.o_req_ready), 32'(tbl[i].e_ready));
         chk($sformatf("v%0d.busy", i), 32'(bus.o_busy), 32'(tbl[i].e_busy));
      end

      // burst limit: requester 2 sends 20 bytes while requester 3 has a 2-byte packet
      do_reset();
      r2 = 0; r3 = 0; cyc = 0;
      while (!(r2 == 20 && r3 == 2) && cyc < 100) begin
         @(negedge clk);
         dw = '0; vw = '0; lw = '0;
         vw[2] = (r2 < 20); dw[23:16] = 8'(r2); lw[2] = (r2 == 19);
         vw[3] = (r3 < 2);  dw[31:24] = 8'hC0 + 8'(r3); lw[3] = (r3 == 1);
         drive(vw, lw, dw, 1'b1);
         #1;
         if (bus.o_tx_valid) begin
            got_data.push_back(bus.o_tx_data);
            got_grant.push_back(bus.o_grant);
         end
         if (vw[2] && bus.o_req_ready[2]) r2++;
         if (vw[3] && bus.o_req_ready[3]) r3++;
         cyc++;
      end
      chk("t3.done_in_budget", 32'(cyc < 100), 32'd1);
      for (int k = 0; k < 16; k++) begin exp_data.push_back(8'(k)); exp_grant.push_back(4'b0100); end
      exp_data.push_back(8'hC0); exp_grant.push_back(4'b1000);
      exp_data.push_back(8'hC1); exp_grant.push_back(4'b1000);
      for (int k = 16; k < 20; k++) begin exp_data.push_back(8'(k)); exp_grant.push_back(4'b0100); end
      chk("t3.xfer_count", 32'(got_data.size()), 32'(exp_data.size()));
      for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
         chk($sformatf("t3.byte%0d", k), 32'(got_data[k]), 32'(exp_data[k]));
         chk($sformatf("t3.src%0d", k), 32'(got_grant[k]), 32'(exp_grant[k]));
      end

      // slow uart_tx: ready low for 10 cycles after each transfer
      do_reset();
      idx = 0; rdy_cnt = 0; nx = 0; g_exp = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         rdy = (rdy_cnt == 0);
         v0  = (idx < 2);
         drive({3'b000, v0}, {3'b000, (idx == 1)}, {24'h0, (idx == 0) ? 8'h55 : 8'hAA}, rdy);
         #1;
         chk($sformatf("t4.c%0d.grant", c), 32'(bus.o_grant), {31'h0, g_exp});
         chk($sformatf("t4.c%0d.tx_valid", c), 32'(bus.o_tx_valid), 32'(g_exp && v0));
         chk($sformatf("t4.c%0d.ready0", c), 32'(bus.o_req_ready[0]), 32'(g_exp && rdy));
         if (bus.o_tx_valid && rdy) begin
            chk($sformatf("t4.byte%0d", nx), 32'(bus.o_tx_data), (nx == 0) ? 32'h55 : 32'hAA);
            nx++;
         end
         xfer_m = g_exp && v0 && rdy;
         if (xfer_m) begin
            idx++;
            rdy_cnt = 10;
            if (idx == 2) g_exp = 1'b0;
         end else begin
            if (rdy_cnt > 0) rdy_cnt--;
            if (!g_exp && v0) g_exp = 1'b1;
         end
      end
      chk("t4.xfer_count", 32'(nx), 32'd2);

      // asynchronous reset mid-packet
      do_reset();
      @(negedge clk);
      drive(4'b0010, 4'b0000, 32'h0000B100, 1'b1);
      @(negedge clk);
      #1;
      chk("t6.granted", 32'(bus.o_grant), 32'b0010);
      @(posedge clk);
      #2;
      drive(4'b0010, 4'b0000, 32'h0000B200, 1'b1);
      #1;
      chk("t6.pre_rst_busy", 32'(bus.o_busy), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6.rst_grant", 32'(bus.o_grant), 32'd0);
      chk("t6.rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
      chk("t6.rst_busy", 32'(bus.o_busy), 32'd0);
      chk("t6.rst_ready", 32'(bus.o_req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0011, 4'b0011, 32'h0000B2D0, 1'b1);
      @(negedge clk);
      #1;
      chk("t6.post_rst_grant", 32'(bus.o_grant), 32'b0001);
      chk("t6.post_rst_data", 32'(bus.o_tx_data), 32'hD0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
